// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op/state encodings and sign helper for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Helper works on a fixed wide vector; callers zero-extend in and truncate out,
    // which gives the correct modular negation at any width up to MD_MAXW.
    localparam int MD_MAXW = 128;

    function automatic logic [MD_MAXW-1:0] cond_neg(input logic [MD_MAXW-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider owning HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_FIX  = ST_FIX;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   count;
    logic               is_div;
    logic               res_sign;
    logic               dvd_sign;

    logic               op_long, op_div, op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign busy      = (state != S_IDLE);
    assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign op_long   = (op == OP_MULT) || (op == OP_MULTU) || op_div;
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    assign a_mag = WIDTH'(cond_neg(MD_MAXW'(a), op_signed & a[WIDTH-1]));
    assign b_mag = WIDTH'(cond_neg(MD_MAXW'(b), op_signed & b[WIDTH-1]));

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? dsr : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, low half dividend becomes the quotient.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_trial = div_shift - {1'b0, dsr};
    assign q_bit     = ~div_trial[WIDTH];
    assign div_next  = {(q_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], q_bit};

    assign prod_fix = (2*WIDTH)'(cond_neg(MD_MAXW'(acc), res_sign));
    assign quo_fix  = WIDTH'(cond_neg(MD_MAXW'(acc[WIDTH-1:0]), res_sign));
    assign rem_fix  = WIDTH'(cond_neg(MD_MAXW'(acc[2*WIDTH-1:WIDTH]), dvd_sign));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= '0;
            dsr         <= '0;
            count       <= '0;
            is_div      <= 1'b0;
            res_sign    <= 1'b0;
            dvd_sign    <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi   <= a;
                            done <= 1'b1;
                        end else if (op == OP_MTLO) begin
                            lo   <= a;
                            done <= 1'b1;
                        end else if (op_long && op_div && (b == '0)) begin
                            hi          <= a;
                            lo          <= '1;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else if (op_long) begin
                            acc      <= {{WIDTH{1'b0}}, a_mag};
                            dsr      <= b_mag;
                            is_div   <= op_div;
                            res_sign <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            dvd_sign <= op_signed & a[WIDTH-1];
                            count    <= WIDTH'(WIDTH);
                            state    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count - 1'b1;
                    if (count == WIDTH'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit owning the HI/LO register pair for the MIPS datapath. It replaces single-cycle combinational MULT/MULTU/DIV/DIVU with an iterative shift-add multiplier and restoring divider that share one datapath. It exposes a start/busy/done handshake so the pipeline stalls only on HI/LO reads that hit a busy unit. It sits beside the ALU in the execute stage; MFHI/MFLO read its `hi`/`lo` outputs directly.

## Interface
- `WIDTH`, default 32: operand width; the product is 2*WIDTH bits, split across HI/LO.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only while `busy`=0.
- `op` in 3: operation select: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a` in WIDTH: rs operand; the dividend for DIV/DIVU; the source value for MTHI/MTLO.
- `b` in WIDTH: rt operand; the divisor for DIV/DIVU.
- `busy` out 1: operation in flight; new `start` is ignored.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result in that cycle.
- `div_by_zero` out 1: valid with `done`; 1 if a DIV/DIVU had `b`=0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE→RUN: `start` with MULT/MULTU/DIV/DIVU and nonzero divisor.
  - RUN→FIX: after WIDTH iterations.
  - FIX→IDLE: always.
- MTHI/MTLO: handled entirely in IDLE. `hi` or `lo` takes `a` at the accept edge; `done` pulses the next cycle; `busy` stays 0.
- Capture at accept:
  - Signed ops store |a| and |b| as unsigned WIDTH-bit magnitudes.
  - Record the result sign (a^b for the product/quotient) and the dividend sign (for the remainder).
  - A WIDTH-bit iteration counter is loaded.
- Multiply: one shift-add step per RUN cycle on a 2*WIDTH accumulator.
- Divide: one restoring step per RUN cycle. Partial remainder is WIDTH+1 bits; quotient shifts in from the LSB.
- FIX (single cycle), applies two's-complement negation per the recorded signs and writes `hi`/`lo`:
  - MULT: negate the 2*WIDTH product when the signs differ.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
- DIV of most-negative by -1: `lo` = most-negative, `hi` = 0. This falls out of the magnitude path and needs no special case.
- Divide by zero (DIV or DIVU): no iteration. At the accept edge, `hi` = `a` and `lo` = all ones. `done` and `div_by_zero` pulse the next cycle; `busy` stays 0.
- `hi`/`lo` change only at MTHI/MTLO accept, at divide-by-zero accept, or at the FIX edge. Intermediate iterations never disturb them.
- `start` while `busy`=1 is dropped, with no queueing. `start` in the same cycle as `done` is accepted.
- Undefined `op` codes are ignored: state unchanged, no `done`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; counter cleared.
- Reset asserted mid-operation aborts immediately and all outputs take their reset values.
- Multi-cycle ops, with start accepted at edge E0:
  - `busy`=1 from after E0 through the FIX edge E(WIDTH+1).
  - `done`=1 for exactly one cycle after E(WIDTH+1).
  - Latency is therefore WIDTH+1 cycles from accept to `done`; 33 cycles for WIDTH=32.
- MTHI, MTLO and divide-by-zero: `done` one cycle after accept.
- `done` is a registered output and never holds longer than one cycle.

## Structure
- Package `muldiv_pkg` holds:
  - the `op` enum with these encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5;
  - the state enum;
  - a parametrised negate/abs helper function.
- Single module, no sub-module. The multiplier and divider share the accumulator and counter.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 cycles after accept; `busy` high 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- DIVU 5 / 0 → one cycle later `done`=1, `div_by_zero`=1, `hi`=5, `lo`=0xFFFFFFFF.
- MTHI 0x1234 → `hi`=0x1234, `done` next cycle, `busy` never 1.
- Issue MULTU 2 × 3; pulse `start` with DIVU at cycle 5 → DIVU ignored; `hi`=0, `lo`=6 at `done`.
- Repeat MULTU 2 × 3 and drop `rst_n` at cycle 10 → all outputs 0 immediately; no `done` follows.
